alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Upstream control stage for the 16-bit ALU. It accepts one command (opcode plus two operands) per transaction over a valid/ready handshake and holds the operands stable on the ALU inputs. It drives the ALU's state and start controls and waits for the ALU's done flag, bounded by a timeout. It then captures the result, carry and zero flags and presents them downstream over a second valid/ready handshake.

Parameters:
TIMEOUT, 64, maximum number of WAIT cycles before the operation is abandoned; legal range 2..65535.
SETTLE, 1, WAIT cycles during which done is ignored for MULT and DIV (0011/0010), so a stale done from the previous operation is masked; must be less than TIMEOUT.

Ports:
clk  in  1  system clock; all logic on the rising edge
reset_a  in  1  reset; synchronous and active-high
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_opcode  in  4  ALU opcode (same encoding as the ALU)
cmd_dataa  in  16  operand A
cmd_datab  in  16  operand B
alu_dataa  out  16  registered operand A to the ALU
alu_datab  out  16  registered operand B to the ALU
alu_opcode  out  4  registered opcode to the ALU
alu_start  out  1  one-cycle start pulse to the ALU
alu_state  out  1  ALU enable; 1 = compute, 0 = ALU outputs forced to zero
alu_out  in  32  ALU result
alu_carry  in  1  ALU carry flag
alu_zero  in  1  ALU zero flag
alu_done  in  1  ALU done flag
res_valid  out  1  result present
res_ready  in  1  consumer accepts the result
res_data  out  32  captured result
res_carry  out  1  captured carry
res_zero  out  1  captured zero
res_opcode  out  4  opcode that produced the result
res_timeout  out  1  1 = operation timed out; res_data is not meaningful
busy  out  1  high in every state except IDLE

Behaviour:
- FSM states: IDLE, LAUNCH, WAIT, HOLD. The state register and all outputs are registered.
- Reset: reset_a is sampled on the clock edge. On reset:
  - state returns to IDLE and the wait counter clears.
  - alu_dataa, alu_datab, alu_opcode, res_data, res_opcode clear to 0.
  - alu_start, alu_state, res_valid, res_carry, res_zero, res_timeout clear to 0.
  - cmd_ready becomes 1 after the reset edge.
  - Reset takes effect in any state, including mid-operation. Any in-flight result is discarded and alu_start is never left high.
- IDLE: cmd_ready=1, alu_state=0.
  - When cmd_valid & cmd_ready, latch opcode and both operands into the alu_* registers and go to LAUNCH.
  - cmd_ready is 0 in every other state.
- LAUNCH (exactly 1 cycle): alu_start=1, alu_state=1, wait counter cleared to 0. Next state is WAIT.
- WAIT: alu_start=0, alu_state=1; the counter increments each cycle and saturates.
  - Done is accepted when alu_done=1 and either the opcode is not MULT/DIV or counter >= SETTLE.
  - On acceptance, capture alu_out, alu_zero and alu_carry, set res_timeout=0, and go to HOLD.
  - Carry masking: res_carry = alu_carry only for ADD (0000) and SUB (0001); it is 0 for all other opcodes.
  - Timeout: if the counter reaches TIMEOUT-1 without an accepted done, go to HOLD with res_timeout=1, res_data=0, res_zero=0, res_carry=0.
  - If done and timeout occur in the same cycle, done wins.
- HOLD: res_valid=1, alu_state=0.
  - All res_* outputs are stable until the cycle in which res_valid & res_ready; then go to IDLE and drop res_valid.
  - There is no overlap: a new command is accepted no earlier than the cycle after the result is consumed.
- Latency: command accepted at edge T; LAUNCH in cycle T..T+1.
  - Single-cycle ops: res_valid rises at edge T+2.
  - MULT/DIV: res_valid rises one edge after the accepted done.
- The alu_* operand and opcode registers change only on command acceptance or reset.
- busy=1 in LAUNCH, WAIT and HOLD.

Test Plan:
- ADD: A=0xFFFF, B=0x0001, ALU model out=0x00010000, carry=1 -> res_data=0x00010000, res_carry=1, res_zero=0, res_valid exactly 2 edges after acceptance.
- MULT: A=0x0100, B=0x0100, model holds stale done=1 in first WAIT cycle and asserts a fresh done 17 cycles after start -> stale done ignored; res_data=0x00010000, res_timeout=0.
- Timeout: DIV with alu_done tied 0, TIMEOUT=64 -> HOLD after 64 WAIT cycles with res_timeout=1, res_data=0; next command is then accepted normally.
- Back-pressure: AND 0x00F0&0x0FF0 with alu_carry forced 1, res_ready low 5 cycles, cmd_valid held high -> res_data=0x000000F0 stable, res_carry=0, cmd_ready=0 until one cycle after the res handshake.
- Reset mid-WAIT: assert reset_a during a MULT WAIT -> next edge IDLE, all outputs at reset values, no res_valid; a following SUB 5-5 gives res_data=0, res_zero=1.
- Done/timeout collision: alu_done rises on the cycle the counter hits TIMEOUT-1 -> result captured with res_timeout=0.

Source files
------------

// File: rtl/alu_sequencer.sv
// Control stage in front of the 16-bit ALU: accepts a command, launches the ALU,
// waits for done (bounded by a timeout) and presents the captured result downstream.
module alu_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int SETTLE  = 1
) (
    input  logic        clk,
    input  logic        reset_a,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_opcode,
    input  logic [15:0] cmd_dataa,
    input  logic [15:0] cmd_datab,
    output logic [15:0] alu_dataa,
    output logic [15:0] alu_datab,
    output logic [3:0]  alu_opcode,
    output logic        alu_start,
    output logic        alu_state,
    input  logic [31:0] alu_out,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        alu_done,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_carry,
    output logic        res_zero,
    output logic [3:0]  res_opcode,
    output logic        res_timeout,
    output logic        busy
);

    localparam logic [3:0]  OP_ADD       = 4'b0000;
    localparam logic [3:0]  OP_SUB       = 4'b0001;
    localparam logic [3:0]  OP_DIV       = 4'b0010;
    localparam logic [3:0]  OP_MULT      = 4'b0011;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] SETTLE_CNT   = 16'(SETTLE);
    localparam logic [15:0] CNT_MAX      = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Multi-cycle ops may still show the done flag of the previous operation.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic keeps_carry(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_nxt_s;
    logic        accept_cmd_s;
    logic        capture_s;
    logic        expire_s;
    logic        done_ok_s;

    assign done_ok_s = alu_done && (!is_long_op(alu_opcode) || (cnt_r >= SETTLE_CNT));

    // Next-state decode, wait counter update and capture/expire strobes.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        accept_cmd_s = 1'b0;
        capture_s    = 1'b0;
        expire_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept_cmd_s = 1'b1;
                    state_nxt_s  = ST_LAUNCH;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                cnt_nxt_s   = 16'd0;
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_r == CNT_MAX) begin
                    cnt_nxt_s = cnt_r;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
                // An accepted done takes priority over the timeout in the same cycle.
                if (done_ok_s) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_HOLD;
                end else if (cnt_r >= TIMEOUT_LAST) begin
                    expire_s    = 1'b1;
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (res_valid && res_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 16'd0;
            end
        endcase
    end

    // State, counter and the per-state control outputs, all decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            cmd_ready <= 1'b1;
            alu_start <= 1'b0;
            alu_state <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            cmd_ready <= (state_nxt_s == ST_IDLE);
            alu_start <= (state_nxt_s == ST_LAUNCH);
            alu_state <= (state_nxt_s == ST_LAUNCH) || (state_nxt_s == ST_WAIT);
            res_valid <= (state_nxt_s == ST_HOLD);
            busy      <= (state_nxt_s != ST_IDLE);
        end
    end

    // Operand/opcode registers toward the ALU; they move only on command acceptance.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            alu_dataa  <= 16'd0;
            alu_datab  <= 16'd0;
            alu_opcode <= 4'd0;
        end else if (accept_cmd_s) begin
            alu_dataa  <= cmd_dataa;
            alu_datab  <= cmd_datab;
            alu_opcode <= cmd_opcode;
        end
    end

    // Result capture; held unchanged through HOLD until the next capture or expiry.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            res_data    <= 32'd0;
            res_carry   <= 1'b0;
            res_zero    <= 1'b0;
            res_opcode  <= 4'd0;
            res_timeout <= 1'b0;
        end else if (capture_s) begin
            res_data    <= alu_out;
            res_carry   <= keeps_carry(alu_opcode) & alu_carry;
            res_zero    <= alu_zero;
            res_opcode  <= alu_opcode;
            res_timeout <= 1'b0;
        end else if (expire_s) begin
            res_data    <= 32'd0;
            res_carry   <= 1'b0;
            res_zero    <= 1'b0;
            res_opcode  <= alu_opcode;
            res_timeout <= 1'b1;
        end
    end

endmodule
